// File: rtl/dco_pkg.sv
// ==== dco_pkg : shared defaults, derived widths and Gray helper for the DCO phase sampler
// ==== rev 1.0
`default_nettype none

package dco_pkg;

  localparam int NUM_STAGES_DEF = 7;
  localparam int CNT_W_DEF      = 8;
  localparam int AVG_LOG2_DEF   = 2;

  localparam int FR_W_DEF = $clog2(2 * NUM_STAGES_DEF);
  localparam int PH_W_DEF = CNT_W_DEF + FR_W_DEF;
  localparam int DW_DEF   = PH_W_DEF + 1;

  // Widest count the helper accepts; callers zero-extend and truncate back.
  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dco_ring_decode.sv
// ==== dco_ring_decode : ring-oscillator snapshot to fractional phase, with invalid-code flag
// ==== rev 1.0
`default_nettype none

module dco_ring_decode
  import dco_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int FR_W       = $clog2(2 * NUM_STAGES)
) (
  input  logic [NUM_STAGES-1:0] ring,
  output logic [FR_W-1:0]       frac,
  output logic                  code_err
);

  localparam logic [FR_W-1:0] RING_LEN = FR_W'(2 * NUM_STAGES);
  localparam logic [FR_W-1:0] STAGES   = FR_W'(NUM_STAGES);

  logic [FR_W-1:0]       pop;
  logic [NUM_STAGES-1:0] low_code;
  logic [NUM_STAGES-1:0] high_code;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      pop = pop + FR_W'(ring[i]);
    end
  end

  // A legal snapshot is a run of ones anchored at bit 0 (rising half) or at
  // the top bit (falling half); both candidates are rebuilt from the popcount.
  always_comb begin
    low_code  = '0;
    high_code = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      low_code[i]  = (FR_W'(i) < pop);
      high_code[i] = (FR_W'(i) >= (STAGES - pop));
    end
  end

  always_comb begin
    code_err = (ring != low_code) && (ring != high_code);
    if (ring[0]) begin
      frac = pop;
    end else if (pop == '0) begin
      frac = '0;
    end else begin
      frac = RING_LEN - pop;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dco_phase_sampler.sv
// ==== dco_phase_sampler : two-stage DCO phase sampler with phase delta and windowed averaging
// ==== rev 1.0
`default_nettype none

module dco_phase_sampler
  import dco_pkg::*;
#(
  parameter  int NUM_STAGES = NUM_STAGES_DEF,
  parameter  int CNT_W      = CNT_W_DEF,
  parameter  int AVG_LOG2   = AVG_LOG2_DEF,
  localparam int FR_W       = $clog2(2 * NUM_STAGES),
  localparam int PH_W       = CNT_W + FR_W,
  localparam int DW         = PH_W + 1,
  localparam int AW         = DW + AVG_LOG2
) (
  input  logic                  refclk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [NUM_STAGES-1:0] ring_state,
  input  logic [CNT_W-1:0]      cnt_gray,
  input  logic                  avg_mode,
  output logic [PH_W-1:0]       dco_phase,
  output logic signed [DW-1:0]  phase_delta,
  output logic                  delta_valid,
  output logic                  bubble_err,
  output logic signed [AW-1:0]  freq_avg,
  output logic                  avg_valid
);

  localparam int WC = AVG_LOG2 + 1;
  localparam logic [WC-1:0]   WIN_LAST = WC'((1 << AVG_LOG2) - 1);
  localparam logic [PH_W-1:0] RING_MOD = PH_W'(2 * NUM_STAGES);

  // Stage 1: raw snapshot; avg_mode travels with the sample it accompanies.
  logic [NUM_STAGES-1:0] ring_q, ring_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  s1_vld_q, s1_vld_d;

  // Stage 2: previous-sample memory and outputs.
  logic [CNT_W-1:0]      cnt_prev_q, cnt_prev_d;
  logic [FR_W-1:0]       frac_prev_q, frac_prev_d;
  logic                  have_prev_q, have_prev_d;
  logic [PH_W-1:0]       dco_phase_q, dco_phase_d;
  logic signed [DW-1:0]  phase_delta_q, phase_delta_d;
  logic                  delta_valid_q, delta_valid_d;
  logic                  bubble_err_q, bubble_err_d;
  logic signed [AW-1:0]  freq_avg_q, freq_avg_d;
  logic                  avg_valid_q, avg_valid_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [WC-1:0]         win_cnt_q, win_cnt_d;

  logic [FR_W-1:0]       frac_w;
  logic                  code_err_w;
  logic [FR_W-1:0]       frac_use_w;
  logic [CNT_W-1:0]      cnt_bin_w;
  logic [CNT_W-1:0]      dcnt_w;
  logic [PH_W-1:0]       scaled_w;
  logic [PH_W-1:0]       phase_w;
  logic signed [DW-1:0]  delta_w;
  logic signed [AW-1:0]  acc_sum_w;

  dco_ring_decode #(
    .NUM_STAGES (NUM_STAGES),
    .FR_W       (FR_W)
  ) u_ring_decode (
    .ring     (ring_q),
    .frac     (frac_w),
    .code_err (code_err_w)
  );

  // An invalid ring code keeps the last good fraction but the count still advances.
  always_comb begin
    frac_use_w = code_err_w ? frac_prev_q : frac_w;
    cnt_bin_w  = CNT_W'(gray2bin(GRAY_MAX_W'(cnt_q)));
    phase_w    = (PH_W'(cnt_bin_w) * RING_MOD) + PH_W'(frac_use_w);
    dcnt_w     = cnt_bin_w - cnt_prev_q;
    scaled_w   = PH_W'(dcnt_w) * RING_MOD;
    delta_w    = $signed({1'b0, scaled_w}) + $signed(DW'(frac_use_w))
                 - $signed(DW'(frac_prev_q));
    acc_sum_w  = acc_q + AW'(delta_w);
  end

  always_comb begin
    ring_d        = ring_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    s1_vld_d      = s1_vld_q;
    cnt_prev_d    = cnt_prev_q;
    frac_prev_d   = frac_prev_q;
    have_prev_d   = have_prev_q;
    dco_phase_d   = dco_phase_q;
    phase_delta_d = phase_delta_q;
    delta_valid_d = delta_valid_q;
    bubble_err_d  = 1'b0;
    freq_avg_d    = freq_avg_q;
    avg_valid_d   = 1'b0;
    acc_d         = acc_q;
    win_cnt_d     = win_cnt_q;

    if (en) begin
      ring_d   = ring_state;
      cnt_d    = cnt_gray;
      mode_d   = avg_mode;
      s1_vld_d = 1'b1;

      if (s1_vld_q) begin
        dco_phase_d  = phase_w;
        cnt_prev_d   = cnt_bin_w;
        frac_prev_d  = frac_use_w;
        have_prev_d  = 1'b1;
        bubble_err_d = code_err_w;

        if (have_prev_q) begin
          phase_delta_d = delta_w;
          delta_valid_d = 1'b1;
        end

        // Dropping out of averaging clears the window, so re-entering restarts it.
        if (!mode_q) begin
          acc_d     = '0;
          win_cnt_d = '0;
        end else if (have_prev_q) begin
          if (win_cnt_q == WIN_LAST) begin
            freq_avg_d  = acc_sum_w;
            avg_valid_d = 1'b1;
            acc_d       = '0;
            win_cnt_d   = '0;
          end else begin
            acc_d     = acc_sum_w;
            win_cnt_d = win_cnt_q + WC'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!resetn) begin
      ring_q        <= '0;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      s1_vld_q      <= 1'b0;
      cnt_prev_q    <= '0;
      frac_prev_q   <= '0;
      have_prev_q   <= 1'b0;
      dco_phase_q   <= '0;
      phase_delta_q <= '0;
      delta_valid_q <= 1'b0;
      bubble_err_q  <= 1'b0;
      freq_avg_q    <= '0;
      avg_valid_q   <= 1'b0;
      acc_q         <= '0;
      win_cnt_q     <= '0;
    end else begin
      ring_q        <= ring_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      s1_vld_q      <= s1_vld_d;
      cnt_prev_q    <= cnt_prev_d;
      frac_prev_q   <= frac_prev_d;
      have_prev_q   <= have_prev_d;
      dco_phase_q   <= dco_phase_d;
      phase_delta_q <= phase_delta_d;
      delta_valid_q <= delta_valid_d;
      bubble_err_q  <= bubble_err_d;
      freq_avg_q    <= freq_avg_d;
      avg_valid_q   <= avg_valid_d;
      acc_q         <= acc_d;
      win_cnt_q     <= win_cnt_d;
    end
  end

  assign dco_phase   = dco_phase_q;
  assign phase_delta = phase_delta_q;
  assign delta_valid = delta_valid_q;
  assign bubble_err  = bubble_err_q;
  assign freq_avg    = freq_avg_q;
  assign avg_valid   = avg_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dco_phase_sampler.sv
// ==== tb_dco_phase_sampler : scoreboard bench with a behavioural phase/frequency model
// ==== rev 1.0
`default_nettype none

module tb_dco_phase_sampler;

  localparam int N    = 7;
  localparam int CW   = 8;
  localparam int AL   = 2;
  localparam int FR_W = 4;
  localparam int PH_W = CW + FR_W;
  localparam int DW   = PH_W + 1;
  localparam int AW   = DW + AL;
  localparam int RL   = 2 * N;

  logic                 refclk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 en = 1'b0;
  logic [N-1:0]         ring_state = '0;
  logic [CW-1:0]        cnt_gray = '0;
  logic                 avg_mode = 1'b0;
  logic [PH_W-1:0]      dco_phase;
  logic signed [DW-1:0] phase_delta;
  logic                 delta_valid;
  logic                 bubble_err;
  logic signed [AW-1:0] freq_avg;
  logic                 avg_valid;

  always #5 refclk = ~refclk;

  dco_phase_sampler #(
    .NUM_STAGES (N),
    .CNT_W      (CW),
    .AVG_LOG2   (AL)
  ) dut (
    .refclk      (refclk),
    .resetn      (resetn),
    .en          (en),
    .ring_state  (ring_state),
    .cnt_gray    (cnt_gray),
    .avg_mode    (avg_mode),
    .dco_phase   (dco_phase),
    .phase_delta (phase_delta),
    .delta_valid (delta_valid),
    .bubble_err  (bubble_err),
    .freq_avg    (freq_avg),
    .avg_valid   (avg_valid)
  );

  typedef struct {
    int phase;
    int delta;
    int dv;
    int bub;
    int favg;
    int av;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   m_prev_frac, m_prev_bin, m_delta, m_favg;
  bit   m_have_prev, m_dv;
  int   m_win[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ring_code(int k);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      if (k <= N) r[i] = (i < k);
      else        r[i] = !(i < k - N);
    end
    return r;
  endfunction

  function automatic int find_k(logic [N-1:0] r);
    for (int k = 0; k < RL; k++) begin
      if (ring_code(k) == r) return k;
    end
    return -1;
  endfunction

  function automatic logic [CW-1:0] gray_of(int b);
    logic [CW-1:0] v;
    v = CW'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int bin_of_gray(logic [CW-1:0] g);
    for (int b = 0; b < (1 << CW); b++) begin
      if (gray_of(b) == g) return b;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_prev_frac = 0;
    m_prev_bin  = 0;
    m_delta     = 0;
    m_favg      = 0;
    m_have_prev = 0;
    m_dv        = 0;
    m_win.delete();
    sb_q.delete();
  endtask

  task automatic model_sample(logic [N-1:0] r, logic [CW-1:0] g, bit mode);
    exp_t e;
    int   k, frac, bin, sum;
    bit   got_delta;
    k    = find_k(r);
    frac = (k < 0) ? m_prev_frac : k;
    bin  = bin_of_gray(g);
    got_delta = m_have_prev;
    if (got_delta) begin
      m_delta = (((bin - m_prev_bin) + (1 << CW)) % (1 << CW)) * RL + (frac - m_prev_frac);
      m_dv    = 1;
    end
    e.av = 0;
    if (!mode) begin
      m_win.delete();
    end else if (got_delta) begin
      m_win.push_back(m_delta);
      if (m_win.size() == (1 << AL)) begin
        sum = 0;
        foreach (m_win[i]) sum += m_win[i];
        m_favg = sum;
        e.av   = 1;
        m_win.delete();
      end
    end
    m_prev_frac = frac;
    m_prev_bin  = bin;
    m_have_prev = 1;
    e.phase = bin * RL + frac;
    e.delta = m_delta;
    e.dv    = m_dv;
    e.bub   = (k < 0);
    e.favg  = m_favg;
    sb_q.push_back(e);
  endtask

  // Monitor: a sample loaded at one enabled edge is presented at the next enabled edge.
  initial begin : monitor
    exp_t last, e;
    int   en_edges;
    bit   r, en_s;
    last = '{0, 0, 0, 0, 0, 0};
    en_edges = 0;
    forever begin
      @(posedge refclk);
      r    = resetn;
      en_s = en;
      #1;
      if (!r) begin
        en_edges = 0;
        last = '{0, 0, 0, 0, 0, 0};
        chk("reset_outputs_zero",
            int'(|{dco_phase, phase_delta, delta_valid, bubble_err, freq_avg, avg_valid}), 0);
      end else begin
        if (en_s && en_edges > 0) begin
          if (sb_q.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("dco_phase", int'(dco_phase), e.phase);
            chk("phase_delta", int'(phase_delta), e.delta);
            chk("delta_valid", int'(delta_valid), e.dv);
            chk("bubble_err", int'(bubble_err), e.bub);
            chk("freq_avg", int'(freq_avg), e.favg);
            chk("avg_valid", int'(avg_valid), e.av);
            last = e;
          end
        end else begin
          chk("hold_dco_phase", int'(dco_phase), last.phase);
          chk("hold_phase_delta", int'(phase_delta), last.delta);
          chk("hold_delta_valid", int'(delta_valid), last.dv);
          chk("hold_freq_avg", int'(freq_avg), last.favg);
          chk("idle_pulses", int'(bubble_err) + int'(avg_valid), 0);
        end
        if (en_s) en_edges++;
      end
    end
  end

  // Stimulus is driven at the falling edge; each call advances one cycle.
  task automatic step(bit e, logic [N-1:0] r, int bin, bit m);
    en         = e;
    ring_state = r;
    cnt_gray   = gray_of(bin);
    avg_mode   = m;
    if (resetn && e) model_sample(r, gray_of(bin), m);
    @(negedge refclk);
  endtask

  task automatic do_reset(int cycles);
    resetn = 1'b0;
    model_reset();
    repeat (cycles) begin
      en         = 1'($urandom);
      ring_state = N'($urandom);
      cnt_gray   = CW'($urandom);
      avg_mode   = 1'($urandom);
      @(negedge refclk);
    end
    resetn = 1'b1;
  endtask

  initial begin : stimulus
    int           bin;
    bit           mode;
    logic [N-1:0] r;
    model_reset();
    @(negedge refclk);
    do_reset(3);

    // Steady ring at k=3 with the count advancing by 4
    bin = 10;
    repeat (8) begin
      step(1'b1, ring_code(3), bin, 1'b0);
      bin = (bin + 4) % 256;
    end
    chk("steady_delta_56", int'(phase_delta), 56);
    chk("steady_valid", int'(delta_valid), 1);

    // Counter wrap 254 -> 2 with fraction 10 -> 1
    step(1'b1, ring_code(10), 254, 1'b0);
    step(1'b1, ring_code(1), 2, 1'b0);
    step(1'b1, ring_code(1), 6, 1'b0);
    chk("wrap_delta_47", int'(phase_delta), 47);

    // Bubble code holds the previous fraction
    step(1'b1, ring_code(5), 20, 1'b0);
    step(1'b1, 7'b0000101, 21, 1'b0);
    step(1'b1, ring_code(5), 22, 1'b0);
    chk("bubble_pulse", int'(bubble_err), 1);
    chk("bubble_frac_held", int'(dco_phase), 21 * RL + 5);
    step(1'b1, ring_code(5), 23, 1'b0);
    chk("bubble_cleared", int'(bubble_err), 0);

    // Averaging with a constant delta of 56
    bin = 30;
    step(1'b1, ring_code(3), bin, 1'b0);
    repeat (12) begin
      bin = (bin + 4) % 256;
      step(1'b1, ring_code(3), bin, 1'b1);
    end
    chk("avg_value_224", int'(freq_avg), 224);
    bin = (bin + 4) % 256;
    step(1'b1, ring_code(3), bin, 1'b0);
    repeat (6) begin
      bin = (bin + 4) % 256;
      step(1'b1, ring_code(3), bin, 1'b1);
    end

    // Reset in the middle of a window
    repeat (3) begin
      bin = (bin + 4) % 256;
      step(1'b1, ring_code(3), bin, 1'b1);
    end
    do_reset(2);
    step(1'b1, ring_code(3), bin, 1'b1);
    bin = (bin + 4) % 256;
    step(1'b1, ring_code(3), bin, 1'b1);
    chk("post_reset_dv_low", int'(delta_valid), 0);
    repeat (8) begin
      bin = (bin + 4) % 256;
      step(1'b1, ring_code(3), bin, 1'b1);
    end

    // Randomised traffic
    mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) r = N'($urandom);
      else                            r = ring_code(int'($urandom_range(0, RL - 1)));
      bin = (bin + int'($urandom_range(0, 18))) % 256;
      step($urandom_range(0, 9) != 0, r, bin, mode);
    end
    step(1'b1, ring_code(0), bin, mode);
    step(1'b1, ring_code(0), bin, mode);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
